register_file_sb: RTL and testbench

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/register_file_sb.sv | 112 +++++++++++
 tb/tb_register_file_sb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// Register file with two combinational read ports, one write port and a per-register
// busy scoreboard. Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(DEPTH)-1:0]   read_reg1,
    input  logic [$clog2(DEPTH)-1:0]   read_reg2,
    output logic [DATA_W-1:0]          read_data1,
    output logic [DATA_W-1:0]          read_data2,
    input  logic [$clog2(DEPTH)-1:0]   write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       regWrite,
    input  logic                       reserve_en,
    input  logic [$clog2(DEPTH)-1:0]   reserve_reg,
    output logic                       busy1,
    output logic                       busy2,
    output logic [$clog2(DEPTH):0]     busy_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [AW:0]       busy_count_q;
    logic [AW:0]       busy_count_d;
    logic              wr_ok;
    logic              rsv_ok;
    logic              byp1;
    logic              byp2;

    function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_ok  = regWrite && !is_zero_reg(write_reg);
    assign rsv_ok = reserve_en && !is_zero_reg(reserve_reg);

    // Reservation is applied after the write-clear so a same-cycle reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[write_reg] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[reserve_reg] = 1'b1;
        end
        busy_count_d = popcount(busy_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[write_reg] <= write_data;
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = wr_ok && !reset && (write_reg == read_reg1);
    assign byp2 = wr_ok && !reset && (write_reg == read_reg2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Outputs are forced quiet during reset so a pending bypass cannot leak through.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        busy1      = 1'b0;
        busy2      = 1'b0;
        if (!reset) begin
            if (byp1) begin
                read_data1 = write_data;
            end else if (!is_zero_reg(read_reg1)) begin
                read_data1 = mem_q[read_reg1];
                busy1      = busy_q[read_reg1];
            end
            if (byp2) begin
                read_data2 = write_data;
            end else if (!is_zero_reg(read_reg2)) begin
                read_data2 = mem_q[read_reg2];
                busy2      = busy_q[read_reg2];
            end
        end
    end

    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed scenarios plus randomized traffic
// compared against an array-based model of the register file and scoreboard.
module tb_register_file_sb;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 32;
    localparam int ZERO_REG = 1;
    localparam int AW       = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [AW-1:0]     read_reg1 = '0;
    logic [AW-1:0]     read_reg2 = '0;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [AW-1:0]     write_reg = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic              regWrite = 1'b0;
    logic              reserve_en = 1'b0;
    logic [AW-1:0]     reserve_reg = '0;
    logic              busy1;
    logic              busy2;
    logic [AW:0]       busy_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_busy [DEPTH];

    register_file_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) dut (
        .clk(clk), .reset(reset),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .write_reg(write_reg), .write_data(write_data), .regWrite(regWrite),
        .reserve_en(reserve_en), .reserve_reg(reserve_reg),
        .busy1(busy1), .busy2(busy2), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_is_zero(input int a);
        return (ZERO_REG != 0) && (a == 0);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic bit m_bypass(input int a);
`ifdef REGFILE_BYPASS_EN
        return !reset && regWrite && (int'(write_reg) == a) && !m_is_zero(a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] m_read(input int a);
        if (m_is_zero(a)) return '0;
        if (m_bypass(a)) return write_data;
        return m_mem[a];
    endfunction

    function automatic bit m_busy_rd(input int a);
        if (m_is_zero(a) || m_bypass(a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic m_edge();
        if (regWrite && !m_is_zero(int'(write_reg))) begin
            m_mem[write_reg]  = write_data;
            m_busy[write_reg] = 1'b0;
        end
        if (reserve_en && !m_is_zero(int'(reserve_reg))) m_busy[reserve_reg] = 1'b1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (!reset) m_edge();
        #1;
    endtask

    task automatic idle();
        regWrite   = 1'b0;
        reserve_en = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        m_reset();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if (busy_count !== 0) $display("FAIL reset_count got %0d exp 0", busy_count);
        else pass_cnt++;
        for (int a = 0; a < DEPTH; a++) begin
            read_reg1 = AW'(a);
            read_reg2 = AW'(DEPTH - 1 - a);
            #1;
            chk_cnt++;
            if (read_data1 !== '0 || read_data2 !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
                $display("FAIL reset_read addr=%0d got d1=%h d2=%h b1=%b b2=%b exp all 0",
                         a, read_data1, read_data2, busy1, busy2);
            end else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        do_reset();
        regWrite = 1'b1; write_reg = 5; write_data = 32'hDEADBEEF;
        tick();
        idle();
        read_reg1 = 5;
        #1;
        chk_cnt++;
        if (read_data1 !== 32'hDEADBEEF) $display("FAIL write_reg5 got %h exp deadbeef", read_data1);
        else pass_cnt++;
        regWrite = 1'b1; write_reg = 0; write_data = 32'h1234;
        tick();
        idle();
        read_reg1 = 0;
        #1;
        chk_cnt++;
        if (read_data1 !== '0) $display("FAIL zero_reg_write got %h exp 0", read_data1);
        else pass_cnt++;
        reserve_en = 1'b1; reserve_reg = 0;
        tick();
        idle();
        chk_cnt++;
        if (busy_count !== 0 || busy1 !== 1'b0)
            $display("FAIL zero_reg_reserve got count=%0d b1=%b exp 0/0", busy_count, busy1);
        else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        do_reset();
        reserve_en = 1'b1; reserve_reg = 7;
        tick();
        chk_cnt++;
        if (busy_count !== 1) $display("FAIL sb_count1 got %0d exp 1", busy_count);
        else pass_cnt++;
        reserve_reg = 9;
        tick();
        idle();
        read_reg1 = 7;
        #1;
        chk_cnt++;
        if (busy_count !== 2) $display("FAIL sb_count2 got %0d exp 2", busy_count);
        else pass_cnt++;
        chk_cnt++;
        if (busy1 !== 1'b1) $display("FAIL sb_busy7 got %b exp 1", busy1);
        else pass_cnt++;
        regWrite = 1'b1; write_reg = 7; write_data = 32'h55;
        tick();
        idle();
        read_reg2 = 9;
        #1;
        chk_cnt++;
        if (busy_count !== 1 || read_data1 !== 32'h55 || busy1 !== 1'b0 || busy2 !== 1'b1)
            $display("FAIL sb_write7 got count=%0d d1=%h b1=%b b2=%b exp 1/55/0/1",
                     busy_count, read_data1, busy1, busy2);
        else pass_cnt++;
        regWrite = 1'b1; write_reg = 12; write_data = 32'h0BAD;
        tick();
        idle();
        read_reg1 = 12;
        #1;
        chk_cnt++;
        if (busy_count !== 1 || read_data1 !== 32'h0BAD || busy1 !== 1'b0)
            $display("FAIL sb_write_free got count=%0d d1=%h b1=%b exp 1/bad/0",
                     busy_count, read_data1, busy1);
        else pass_cnt++;
    endtask

    task automatic test_set_wins();
        do_reset();
        reserve_en = 1'b1; reserve_reg = 3;
        regWrite = 1'b1; write_reg = 3; write_data = 32'hA;
        tick();
        idle();
        read_reg1 = 3;
        read_reg2 = 3;
        #1;
        chk_cnt++;
        if (busy1 !== 1'b1 || read_data1 !== 32'hA || busy_count !== 1)
            $display("FAIL set_wins got b1=%b d1=%h count=%0d exp 1/a/1", busy1, read_data1, busy_count);
        else pass_cnt++;
        chk_cnt++;
        if (read_data2 !== read_data1 || busy2 !== busy1)
            $display("FAIL same_addr got d2=%h b2=%b exp %h/%b", read_data2, busy2, read_data1, busy1);
        else pass_cnt++;
        reserve_en = 1'b1; reserve_reg = 3;
        tick();
        idle();
        chk_cnt++;
        if (busy_count !== 1) $display("FAIL re_reserve got %0d exp 1", busy_count);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        do_reset();
        regWrite = 1'b1; write_reg = 4; write_data = 32'h11;
        tick();
        idle();
        reserve_en = 1'b1; reserve_reg = 4;
        tick();
        idle();
        read_reg2 = 4;
        regWrite = 1'b1; write_reg = 4; write_data = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk_cnt++;
        if (read_data2 !== 32'h77 || busy2 !== 1'b0)
            $display("FAIL bypass_same_cycle got d2=%h b2=%b exp 77/0", read_data2, busy2);
        else pass_cnt++;
`else
        chk_cnt++;
        if (read_data2 !== 32'h11 || busy2 !== 1'b1)
            $display("FAIL nobypass_same_cycle got d2=%h b2=%b exp 11/1", read_data2, busy2);
        else pass_cnt++;
`endif
        tick();
        idle();
        #1;
        chk_cnt++;
        if (read_data2 !== 32'h77 || busy2 !== 1'b0 || busy_count !== 0)
            $display("FAIL bypass_next_cycle got d2=%h b2=%b count=%0d exp 77/0/0",
                     read_data2, busy2, busy_count);
        else pass_cnt++;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            regWrite    = ($urandom_range(0, 2) == 0);
            write_reg   = AW'($urandom_range(0, DEPTH - 1));
            write_data  = $urandom();
            reserve_en  = ($urandom_range(0, 1) == 0);
            reserve_reg = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, DEPTH - 1));
            read_reg1   = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, DEPTH - 1));
            read_reg2   = ($urandom_range(0, 4) == 0) ? read_reg1 : AW'($urandom_range(0, DEPTH - 1));
            #1;
            chk_cnt++;
            if (read_data1 !== m_read(int'(read_reg1)) || read_data2 !== m_read(int'(read_reg2)))
                $display("FAIL rand_data n=%0d got %h/%h exp %h/%h", n, read_data1, read_data2,
                         m_read(int'(read_reg1)), m_read(int'(read_reg2)));
            else pass_cnt++;
            chk_cnt++;
            if (busy1 !== m_busy_rd(int'(read_reg1)) || busy2 !== m_busy_rd(int'(read_reg2)))
                $display("FAIL rand_busy n=%0d got %b/%b exp %b/%b", n, busy1, busy2,
                         m_busy_rd(int'(read_reg1)), m_busy_rd(int'(read_reg2)));
            else pass_cnt++;
            chk_cnt++;
            if (int'(busy_count) !== m_count())
                $display("FAIL rand_count n=%0d got %0d exp %0d", n, busy_count, m_count());
            else pass_cnt++;
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 1; k < 8; k++) begin
            regWrite = 1'b1; write_reg = AW'(k * 3); write_data = 32'h100 + k;
            reserve_en = (k == 2 || k == 4 || k == 6);
            reserve_reg = AW'(k * 4);
            tick();
        end
        idle();
        #1;
        chk_cnt++;
        if (busy_count !== 3) $display("FAIL pre_reset_count got %0d exp 3", busy_count);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        chk_cnt++;
        if (busy_count !== 0) $display("FAIL async_reset_count got %0d exp 0", busy_count);
        else pass_cnt++;
        for (int k = 1; k < 5; k++) begin
            read_reg1 = AW'(k * 3);
            read_reg2 = AW'(k * 4);
            #1;
            chk_cnt++;
            if (read_data1 !== '0 || read_data2 !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0)
                $display("FAIL async_reset_read k=%0d got %h/%h b=%b%b exp 0", k,
                         read_data1, read_data2, busy1, busy2);
            else pass_cnt++;
        end
        regWrite = 1'b1; write_reg = 6; write_data = 32'h99;
        reserve_en = 1'b1; reserve_reg = 6;
        tick();
        #3;
        idle();
        reset = 1'b0;
        read_reg1 = 6;
        #1;
        chk_cnt++;
        if (read_data1 !== '0 || busy1 !== 1'b0 || busy_count !== 0)
            $display("FAIL write_during_reset got d1=%h b1=%b count=%0d exp 0/0/0",
                     read_data1, busy1, busy_count);
        else pass_cnt++;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_write_read();
        test_scoreboard();
        test_set_wins();
        test_bypass();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
